axi_rdata_router: RTL and testbench
===================================

Name: axi_rdata_router

Overview:
- Read-data (R) channel crossbar for the AXI interconnect; sits downstream of the read-address path.
- Collects R beats from slave 0 (IM), slave 1 (DM) and the default slave, and routes each burst back to master 0 or master 1.
- The target master is decoded from the extended slave-side RID upper bits.
- One burst is in flight at a time; slave ownership is round-robin and locked until the RLAST handshake.

Parameters:
- DATA_BITS, 32, RDATA width
- ID_BITS, 4, master-side RID width
- IDS_BITS, 8, slave-side RID width; upper IDS_BITS-ID_BITS bits are the master tag

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- S0_RID / S1_RID / DS_RID  in  IDS_BITS  slave RID
- S0_RData / S1_RData / DS_RData  in  DATA_BITS  slave read data
- S0_RResp / S1_RResp / DS_RResp  in  2  slave response
- S0_RLast / S1_RLast / DS_RLast  in  1  last beat
- S0_RValid / S1_RValid / DS_RValid  in  1  beat valid
- S0_RReady / S1_RReady / DS_RReady  out  1  beat accepted
- M0_RID / M1_RID  out  ID_BITS  master RID (= slave RID[ID_BITS-1:0])
- M0_RData / M1_RData  out  DATA_BITS  read data
- M0_RResp / M1_RResp  out  2  response
- M0_RLast / M1_RLast  out  1  last beat
- M0_RValid / M1_RValid  out  1  beat valid
- M0_RReady / M1_RReady  in  1  master ready

Behaviour:
- Interface: single clock clk, rising edge. rst is synchronous active-low: sampled on clk edge, all state cleared while rst==0.
- State: FSM {IDLE, LOCK}; grant register gnt (one of S0/S1/DS); round-robin pointer rr (reset → S0); target register tgt ∈ {M0, M1, DROP}.
- Reset:
  - state=IDLE, gnt=S0, rr=S0, tgt=DROP.
  - All xValid/xReady outputs 0; all M data/ID/resp/last outputs 0.
- IDLE:
  - All outputs 0 and no slave ready.
  - If any SxRValid: choose the first valid slave starting at rr in order S0→S1→DS→S0.
  - Latch gnt; decode tgt from the granted RID[IDS_BITS-1:ID_BITS]: 4'b0001→M0, 4'b0010→M1, anything else→DROP.
  - Go to LOCK next cycle. Arbitration latency is 1 cycle; no beat is transferred in IDLE.
- LOCK, tgt=M0/M1:
  - The granted slave's ID[ID_BITS-1:0], Data, Resp, Last and Valid are forwarded combinationally to the target master.
  - The granted slave's RReady equals the target master's RReady.
  - The other master's outputs are 0; the other slaves' RReady is 0.
- LOCK, tgt=DROP:
  - Granted slave RReady=1; beats are discarded.
  - Both masters' RValid=0.
- Leaving LOCK:
  - Handshake (granted RValid & RReady) with RLast=1 → IDLE next cycle; rr ← slave after gnt.
  - Handshake without RLast: stay in LOCK. Master RReady low: stay in LOCK with data held by the slave.
  - No data registers in the router; beats are zero-latency pass-through.
- Ownership: tgt is decoded once per burst. RID changes mid-burst do not re-route.
- Simultaneous valids: only one slave is granted; the others wait with RReady=0 and must hold their beats.
- Back-to-back bursts: minimum one IDLE bubble cycle between RLAST and the next burst's first beat.
- Reset mid-burst (rst=0 in LOCK): outputs forced to 0 next edge, burst abandoned; the slave is expected to be reset simultaneously.

Test Plan:
- Single beat, S0→M0: S0_RID=8'h13, RData=32'hDEAD_BEEF, Last=1, Valid=1; M0_RReady=1.
  - Expect M0_RValid=1 with M0_RID=4'h3, data DEADBEEF on cycle 2.
  - Expect S0_RReady=1 on the same cycle; IDLE on cycle 3; M1_RValid=0 throughout.
- 4-beat burst, S1→M1, with M1_RReady low for 2 cycles mid-burst: S1_RID=8'h25.
  - Expect 4 beats on M1 in order; stall cycles with S1_RReady=0; RLast passed only on beat 4.
- Simultaneous S0, S1, DS valid, all single-beat, tagged M0, after reset:
  - Expect grant order S0, S1, DS, each separated by one IDLE cycle.
  - Repeating the pattern afterwards still grants S0, S1, DS in rr order.
- Invalid tag: DS_RID=8'h37, 2-beat burst.
  - Expect DS_RReady=1 in LOCK, both masters' RValid=0, return to IDLE after the second beat.
- Reset mid-burst: during beat 2 of a 4-beat S0→M1 burst, drive rst=0 for 1 cycle.
  - Expect all valid/ready outputs 0 on the next cycle and state=IDLE, rr=S0.
- RID change mid-burst: S1 burst tagged M0, with RID switched to 8'h2x on beat 2.
  - Expect all beats delivered to M0.

Source files
------------

// File: rtl/axi_rdata_router.sv
// rtl/axi_rdata_router.sv - AXI R-channel router: three slaves (S0, S1, DS) to two masters
// One burst owns the path from grant until its RLAST handshake; beats pass through with zero latency.
module axi_rdata_router #(
  parameter int DATA_BITS = 32,
  parameter int ID_BITS   = 4,
  parameter int IDS_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDS_BITS-1:0]  S0_RID,
  input  logic [DATA_BITS-1:0] S0_RData,
  input  logic [1:0]           S0_RResp,
  input  logic                 S0_RLast,
  input  logic                 S0_RValid,
  output logic                 S0_RReady,
  input  logic [IDS_BITS-1:0]  S1_RID,
  input  logic [DATA_BITS-1:0] S1_RData,
  input  logic [1:0]           S1_RResp,
  input  logic                 S1_RLast,
  input  logic                 S1_RValid,
  output logic                 S1_RReady,
  input  logic [IDS_BITS-1:0]  DS_RID,
  input  logic [DATA_BITS-1:0] DS_RData,
  input  logic [1:0]           DS_RResp,
  input  logic                 DS_RLast,
  input  logic                 DS_RValid,
  output logic                 DS_RReady,
  output logic [ID_BITS-1:0]   M0_RID,
  output logic [DATA_BITS-1:0] M0_RData,
  output logic [1:0]           M0_RResp,
  output logic                 M0_RLast,
  output logic                 M0_RValid,
  input  logic                 M0_RReady,
  output logic [ID_BITS-1:0]   M1_RID,
  output logic [DATA_BITS-1:0] M1_RData,
  output logic [1:0]           M1_RResp,
  output logic                 M1_RLast,
  output logic                 M1_RValid,
  input  logic                 M1_RReady
);

  localparam int TAG_BITS = IDS_BITS - ID_BITS;

  typedef enum logic {ST_IDLE, ST_LOCK} state_t;
  typedef enum logic [1:0] {SEL_S0 = 2'd0, SEL_S1 = 2'd1, SEL_DS = 2'd2} sel_t;
  typedef enum logic [1:0] {TGT_M0 = 2'd0, TGT_M1 = 2'd1, TGT_DROP = 2'd2} tgt_t;

  state_t state_q, state_d;
  sel_t   gnt_q, gnt_d;
  sel_t   rr_q, rr_d;
  tgt_t   tgt_q, tgt_d;

  sel_t                 pick;
  logic [2:0]           valid_vec;
  logic [TAG_BITS-1:0]  pick_tag;
  logic [ID_BITS-1:0]   g_id;
  logic [DATA_BITS-1:0] g_data;
  logic [1:0]           g_resp;
  logic                 g_last;
  logic                 g_valid;
  logic                 g_ready;
  logic                 hs;

  function automatic sel_t next_sel(input sel_t s);
    case (s)
      SEL_S0:  next_sel = SEL_S1;
      SEL_S1:  next_sel = SEL_DS;
      default: next_sel = SEL_S0;
    endcase
  endfunction

  // Round-robin pick: first valid slave at or after rr, wrapping S0 -> S1 -> DS.
  always_comb begin
    valid_vec = {DS_RValid, S1_RValid, S0_RValid};
    pick      = rr_q;
    case (rr_q)
      SEL_S0: begin
        if (valid_vec[0])      pick = SEL_S0;
        else if (valid_vec[1]) pick = SEL_S1;
        else                   pick = SEL_DS;
      end
      SEL_S1: begin
        if (valid_vec[1])      pick = SEL_S1;
        else if (valid_vec[2]) pick = SEL_DS;
        else                   pick = SEL_S0;
      end
      default: begin
        if (valid_vec[2])      pick = SEL_DS;
        else if (valid_vec[0]) pick = SEL_S0;
        else                   pick = SEL_S1;
      end
    endcase
    case (pick)
      SEL_S0:  pick_tag = S0_RID[IDS_BITS-1:ID_BITS];
      SEL_S1:  pick_tag = S1_RID[IDS_BITS-1:ID_BITS];
      default: pick_tag = DS_RID[IDS_BITS-1:ID_BITS];
    endcase
  end

  always_comb begin
    case (gnt_q)
      SEL_S0: begin
        g_id    = S0_RID[ID_BITS-1:0];
        g_data  = S0_RData;
        g_resp  = S0_RResp;
        g_last  = S0_RLast;
        g_valid = S0_RValid;
      end
      SEL_S1: begin
        g_id    = S1_RID[ID_BITS-1:0];
        g_data  = S1_RData;
        g_resp  = S1_RResp;
        g_last  = S1_RLast;
        g_valid = S1_RValid;
      end
      default: begin
        g_id    = DS_RID[ID_BITS-1:0];
        g_data  = DS_RData;
        g_resp  = DS_RResp;
        g_last  = DS_RLast;
        g_valid = DS_RValid;
      end
    endcase
  end

  // Everything idles at zero unless a burst holds the path.
  always_comb begin
    M0_RID    = '0;
    M0_RData  = '0;
    M0_RResp  = '0;
    M0_RLast  = 1'b0;
    M0_RValid = 1'b0;
    M1_RID    = '0;
    M1_RData  = '0;
    M1_RResp  = '0;
    M1_RLast  = 1'b0;
    M1_RValid = 1'b0;
    S0_RReady = 1'b0;
    S1_RReady = 1'b0;
    DS_RReady = 1'b0;
    g_ready   = 1'b0;
    if (state_q == ST_LOCK) begin
      case (tgt_q)
        TGT_M0: begin
          M0_RID    = g_id;
          M0_RData  = g_data;
          M0_RResp  = g_resp;
          M0_RLast  = g_last;
          M0_RValid = g_valid;
          g_ready   = M0_RReady;
        end
        TGT_M1: begin
          M1_RID    = g_id;
          M1_RData  = g_data;
          M1_RResp  = g_resp;
          M1_RLast  = g_last;
          M1_RValid = g_valid;
          g_ready   = M1_RReady;
        end
        default: g_ready = 1'b1;
      endcase
      case (gnt_q)
        SEL_S0:  S0_RReady = g_ready;
        SEL_S1:  S1_RReady = g_ready;
        default: DS_RReady = g_ready;
      endcase
    end
    hs = (state_q == ST_LOCK) && g_valid && g_ready;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    tgt_d   = tgt_q;
    case (state_q)
      ST_IDLE: begin
        if (|valid_vec) begin
          state_d = ST_LOCK;
          gnt_d   = pick;
          if (pick_tag == TAG_BITS'(1))      tgt_d = TGT_M0;
          else if (pick_tag == TAG_BITS'(2)) tgt_d = TGT_M1;
          else                               tgt_d = TGT_DROP;
        end
      end
      default: begin
        if (hs && g_last) begin
          state_d = ST_IDLE;
          rr_d    = next_sel(gnt_q);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= SEL_S0;
      rr_q    <= SEL_S0;
      tgt_q   <= TGT_DROP;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      tgt_q   <= tgt_d;
    end
  end

endmodule

// File: tb/tb_axi_rdata_router.sv
// tb/tb_axi_rdata_router.sv - self-checking bench for axi_rdata_router
// Directed scenarios followed by a randomized run scored against a burst-level model.
module tb_axi_rdata_router;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_rid   [3];
  logic [31:0] s_data  [3];
  logic [1:0]  s_resp  [3];
  logic        s_last  [3];
  logic        s_valid [3];
  logic        m0_rready, m1_rready;
  wire         s0_rready, s1_rready, ds_rready;
  wire [3:0]   m0_rid, m1_rid;
  wire [31:0]  m0_rdata, m1_rdata;
  wire [1:0]   m0_rresp, m1_rresp;
  wire         m0_rlast, m1_rlast, m0_rvalid, m1_rvalid;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0]  rid;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        first;
    logic [1:0]  dest;
  } beat_t;

  always #5 clk = ~clk;

  axi_rdata_router #(.DATA_BITS(32), .ID_BITS(4), .IDS_BITS(8)) dut (
    .clk(clk), .rst(rst),
    .S0_RID(s_rid[0]), .S0_RData(s_data[0]), .S0_RResp(s_resp[0]), .S0_RLast(s_last[0]),
    .S0_RValid(s_valid[0]), .S0_RReady(s0_rready),
    .S1_RID(s_rid[1]), .S1_RData(s_data[1]), .S1_RResp(s_resp[1]), .S1_RLast(s_last[1]),
    .S1_RValid(s_valid[1]), .S1_RReady(s1_rready),
    .DS_RID(s_rid[2]), .DS_RData(s_data[2]), .DS_RResp(s_resp[2]), .DS_RLast(s_last[2]),
    .DS_RValid(s_valid[2]), .DS_RReady(ds_rready),
    .M0_RID(m0_rid), .M0_RData(m0_rdata), .M0_RResp(m0_rresp), .M0_RLast(m0_rlast),
    .M0_RValid(m0_rvalid), .M0_RReady(m0_rready),
    .M1_RID(m1_rid), .M1_RData(m1_rdata), .M1_RResp(m1_rresp), .M1_RLast(m1_rlast),
    .M1_RValid(m1_rvalid), .M1_RReady(m1_rready)
  );

  function automatic logic [2:0] rdy_vec();
    return {ds_rready, s1_rready, s0_rready};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int s, input logic [7:0] rid, input logic [31:0] d,
                       input logic [1:0] r, input logic l, input logic v);
    s_rid[s]   = rid;
    s_data[s]  = d;
    s_resp[s]  = r;
    s_last[s]  = l;
    s_valid[s] = v;
  endtask

  task automatic clear_inputs();
    for (int s = 0; s < 3; s++) drive(s, 8'h00, 32'h0, 2'b00, 1'b0, 1'b0);
    m0_rready = 1'b0;
    m1_rready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 3; s++) drive(s, 8'h10, 32'hFFFF_FFFF, 2'b11, 1'b1, 1'b1);
    m0_rready = 1'b1;
    m1_rready = 1'b1;
    rst = 1'b0;
    repeat (2) tick();
    #1;
    total++;
    if (rdy_vec() !== 3'b000) begin
      bad++;
      $display("FAIL reset_ready: got %b want 000", rdy_vec());
    end
    total++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
      bad++;
      $display("FAIL reset_valid: got %b want 00", {m0_rvalid, m1_rvalid});
    end
    total++;
    if ({m0_rid, m0_rdata, m0_rresp, m0_rlast, m1_rid, m1_rdata, m1_rresp, m1_rlast} !== '0) begin
      bad++;
      $display("FAIL reset_data: m0 %h/%h m1 %h/%h want all zero", m0_rid, m0_rdata, m1_rid, m1_rdata);
    end
    clear_inputs();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_beat();
    drive(0, 8'h13, 32'hDEAD_BEEF, 2'b00, 1'b1, 1'b1);
    m0_rready = 1'b1;
    m1_rready = 1'b1;
    #1;
    total++;
    if (s0_rready !== 1'b0 || m0_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL single_arb_cycle: s0_rready=%b m0_rvalid=%b want 0 0", s0_rready, m0_rvalid);
    end
    tick();
    #1;
    total++;
    if (m0_rvalid !== 1'b1 || m0_rid !== 4'h3 || m0_rdata !== 32'hDEAD_BEEF || m0_rlast !== 1'b1
        || s0_rready !== 1'b1 || m1_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL single_lock: m0v=%b id=%h data=%h last=%b s0r=%b m1v=%b want 1 3 deadbeef 1 1 0",
               m0_rvalid, m0_rid, m0_rdata, m0_rlast, s0_rready, m1_rvalid);
    end
    tick();
    drive(0, 8'h1A, 32'h0BAD_F00D, 2'b01, 1'b1, 1'b1);
    #1;
    total++;
    if (s0_rready !== 1'b0 || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL single_bubble: s0r=%b m0v=%b m1v=%b want 0 0 0", s0_rready, m0_rvalid, m1_rvalid);
    end
    tick();
    #1;
    total++;
    if (m0_rvalid !== 1'b1 || m0_rid !== 4'hA || m0_rdata !== 32'h0BAD_F00D || m0_rresp !== 2'b01) begin
      bad++;
      $display("FAIL single_second: m0v=%b id=%h data=%h resp=%b want 1 a 0badf00d 01",
               m0_rvalid, m0_rid, m0_rdata, m0_rresp);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_stall_burst();
    int  k;
    logic exp_rdy;
    k = 0;
    drive(1, 8'h25, 32'h1000, 2'b00, 1'b0, 1'b1);
    m1_rready = 1'b1;
    #1;
    total++;
    if (s1_rready !== 1'b0) begin
      bad++;
      $display("FAIL stall_arb_cycle: s1_rready=%b want 0", s1_rready);
    end
    tick();
    for (int c = 0; c < 6; c++) begin
      exp_rdy   = !(c == 2 || c == 3);
      m1_rready = exp_rdy;
      drive(1, 8'h25, 32'h1000 + 32'(k), 2'(k), k == 3, 1'b1);
      #1;
      total++;
      if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h1000 + 32'(k) || m1_rlast !== (k == 3)
          || m1_rid !== 4'h5 || s1_rready !== exp_rdy || m0_rvalid !== 1'b0) begin
        bad++;
        $display("FAIL stall_beat c=%0d: m1v=%b data=%h last=%b id=%h s1r=%b m0v=%b want 1 %h %b 5 %b 0",
                 c, m1_rvalid, m1_rdata, m1_rlast, m1_rid, s1_rready, m0_rvalid,
                 32'h1000 + 32'(k), k == 3, exp_rdy);
      end
      if (exp_rdy) k++;
      tick();
    end
    clear_inputs();
    #1;
    total++;
    if (m1_rvalid !== 1'b0 || s1_rready !== 1'b0) begin
      bad++;
      $display("FAIL stall_end: m1v=%b s1r=%b want 0 0", m1_rvalid, s1_rready);
    end
  endtask

  task automatic test_round_robin();
    int exp;
    do_reset();
    for (int s = 0; s < 3; s++) drive(s, 8'h10 | 8'(s), 32'hA000_0000 + 32'(s), 2'b00, 1'b1, 1'b1);
    m0_rready = 1'b1;
    for (int g = 0; g < 6; g++) begin
      exp = g % 3;
      #1;
      total++;
      if (rdy_vec() !== 3'b000 || m0_rvalid !== 1'b0) begin
        bad++;
        $display("FAIL rr_bubble g=%0d: ready=%b m0v=%b want 000 0", g, rdy_vec(), m0_rvalid);
      end
      tick();
      #1;
      total++;
      if (rdy_vec() !== 3'(1 << exp) || m0_rvalid !== 1'b1 || m0_rdata !== 32'hA000_0000 + 32'(exp)) begin
        bad++;
        $display("FAIL rr_grant g=%0d: ready=%b m0v=%b data=%h want %b 1 %h", g, rdy_vec(), m0_rvalid,
                 m0_rdata, 3'(1 << exp), 32'hA000_0000 + 32'(exp));
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_drop();
    m0_rready = 1'b1;
    m1_rready = 1'b1;
    drive(2, 8'h37, 32'h5555_0000, 2'b00, 1'b0, 1'b1);
    #1;
    total++;
    if (ds_rready !== 1'b0) begin
      bad++;
      $display("FAIL drop_arb_cycle: ds_rready=%b want 0", ds_rready);
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(2, 8'h37, 32'h5555_0000 + 32'(k), 2'b00, k == 1, 1'b1);
      #1;
      total++;
      if (ds_rready !== 1'b1 || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
        bad++;
        $display("FAIL drop_beat k=%0d: dsr=%b m0v=%b m1v=%b want 1 0 0", k, ds_rready, m0_rvalid, m1_rvalid);
      end
      tick();
    end
    drive(2, 8'h37, 32'h5555_0002, 2'b00, 1'b1, 1'b1);
    #1;
    total++;
    if (ds_rready !== 1'b0) begin
      bad++;
      $display("FAIL drop_idle_after: ds_rready=%b want 0", ds_rready);
    end
    tick();
    #1;
    total++;
    if (ds_rready !== 1'b1 || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL drop_next: dsr=%b m0v=%b m1v=%b want 1 0 0", ds_rready, m0_rvalid, m1_rvalid);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid_burst();
    m0_rready = 1'b1;
    m1_rready = 1'b1;
    drive(0, 8'h1F, 32'h1, 2'b00, 1'b1, 1'b1);
    tick();
    tick();
    drive(0, 8'h2C, 32'h2000, 2'b00, 1'b0, 1'b1);
    tick();
    #1;
    total++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h2000 || s0_rready !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_beat1: m1v=%b data=%h s0r=%b want 1 2000 1", m1_rvalid, m1_rdata, s0_rready);
    end
    tick();
    drive(0, 8'h2C, 32'h2001, 2'b00, 1'b0, 1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    clear_inputs();
    drive(0, 8'h10, 32'h0000_00C0, 2'b00, 1'b1, 1'b1);
    drive(1, 8'h11, 32'h0000_00C1, 2'b00, 1'b1, 1'b1);
    m0_rready = 1'b1;
    #1;
    total++;
    if (rdy_vec() !== 3'b000 || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || m1_rdata !== 32'h0) begin
      bad++;
      $display("FAIL rstmid_cleared: ready=%b m0v=%b m1v=%b m1data=%h want 000 0 0 0",
               rdy_vec(), m0_rvalid, m1_rvalid, m1_rdata);
    end
    tick();
    #1;
    total++;
    if (rdy_vec() !== 3'b001 || m0_rdata !== 32'h0000_00C0) begin
      bad++;
      $display("FAIL rstmid_rr: ready=%b data=%h want 001 000000c0", rdy_vec(), m0_rdata);
    end
    tick();
    drive(0, 8'h00, 32'h0, 2'b00, 1'b0, 1'b0);
    tick();
    tick();
    clear_inputs();
  endtask

  task automatic test_rid_change();
    m0_rready = 1'b1;
    m1_rready = 1'b1;
    drive(1, 8'h16, 32'h3000, 2'b00, 1'b0, 1'b1);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1, (k == 0) ? 8'h16 : 8'h26, 32'h3000 + 32'(k), 2'b00, k == 2, 1'b1);
      #1;
      total++;
      if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h3000 + 32'(k) || m0_rid !== 4'h6
          || m1_rvalid !== 1'b0 || s1_rready !== 1'b1) begin
        bad++;
        $display("FAIL ridchg_beat k=%0d: m0v=%b data=%h id=%h m1v=%b s1r=%b want 1 %h 6 0 1",
                 k, m0_rvalid, m0_rdata, m0_rid, m1_rvalid, s1_rready, 32'h3000 + 32'(k));
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_random();
    beat_t      sq [3][$];
    beat_t      b;
    int         exp_order[$];
    int         n [3];
    int         rr, gi, cyc, hs_dest, len;
    logic [2:0] rdy;
    logic [3:0] tag;
    logic       v;
    bit         hold [3];
    bit         prev_last;
    do_reset();
    for (int s = 0; s < 3; s++) begin
      n[s] = $urandom_range(3, 6);
      for (int k = 0; k < n[s]; k++) begin
        len = $urandom_range(1, 4);
        case ($urandom_range(0, 2))
          0:       tag = 4'h1;
          1:       tag = 4'h2;
          default: tag = 4'(3 + $urandom_range(0, 12));
        endcase
        for (int j = 0; j < len; j++) begin
          b.rid   = {(j == 0) ? tag : 4'($urandom), 4'($urandom)};
          b.data  = $urandom;
          b.resp  = 2'($urandom);
          b.last  = (j == len - 1);
          b.first = (j == 0);
          b.dest  = (tag == 4'h1) ? 2'd0 : (tag == 4'h2) ? 2'd1 : 2'd2;
          sq[s].push_back(b);
        end
      end
    end
    // Every slave with work pending holds a first beat valid, so grants follow pure round-robin.
    rr = 0;
    while (n[0] + n[1] + n[2] > 0) begin
      for (int i = 0; i < 3; i++) begin
        int ss;
        ss = (rr + i) % 3;
        if (n[ss] > 0) begin
          exp_order.push_back(ss);
          n[ss]--;
          rr = (ss + 1) % 3;
          break;
        end
      end
    end
    gi = 0;
    cyc = 0;
    prev_last = 1'b0;
    for (int s = 0; s < 3; s++) hold[s] = 1'b0;
    while (sq[0].size() + sq[1].size() + sq[2].size() > 0 && cyc < 4000) begin
      for (int s = 0; s < 3; s++) begin
        if (sq[s].size() > 0) begin
          b = sq[s][0];
          v = hold[s] || b.first || ($urandom_range(0, 3) != 0);
          drive(s, b.rid, b.data, b.resp, b.last, v);
        end else begin
          drive(s, 8'h00, 32'h0, 2'b00, 1'b0, 1'b0);
        end
      end
      m0_rready = ($urandom_range(0, 3) != 0);
      m1_rready = ($urandom_range(0, 3) != 0);
      #1;
      rdy = rdy_vec();
      total++;
      if ($countones(rdy) > 1) begin
        bad++;
        $display("FAIL rand_multi_ready cyc=%0d: ready=%b want at most one", cyc, rdy);
      end
      if (prev_last) begin
        total++;
        if (rdy !== 3'b000 || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
          bad++;
          $display("FAIL rand_bubble cyc=%0d: ready=%b m0v=%b m1v=%b want 000 0 0", cyc, rdy, m0_rvalid, m1_rvalid);
        end
      end
      prev_last = 1'b0;
      hs_dest = -1;
      for (int s = 0; s < 3; s++) begin
        hold[s] = s_valid[s] && !rdy[s];
        if (s_valid[s] && rdy[s]) begin
          b = sq[s].pop_front();
          hs_dest = int'(b.dest);
          prev_last = b.last;
          if (b.first) begin
            total++;
            if (gi >= exp_order.size() || exp_order[gi] != s) begin
              bad++;
              $display("FAIL rand_grant_order #%0d: granted slave %0d want %0d", gi, s,
                       (gi < exp_order.size()) ? exp_order[gi] : -1);
            end
            gi++;
          end
          total++;
          case (b.dest)
            2'd0: if (m0_rvalid !== 1'b1 || m0_rready !== 1'b1 || m0_rid !== b.rid[3:0] || m0_rdata !== b.data
                      || m0_rresp !== b.resp || m0_rlast !== b.last || m1_rvalid !== 1'b0) begin
              bad++;
              $display("FAIL rand_m0_beat cyc=%0d: v=%b id=%h data=%h resp=%b last=%b m1v=%b want 1 %h %h %b %b 0",
                       cyc, m0_rvalid, m0_rid, m0_rdata, m0_rresp, m0_rlast, m1_rvalid,
                       b.rid[3:0], b.data, b.resp, b.last);
            end
            2'd1: if (m1_rvalid !== 1'b1 || m1_rready !== 1'b1 || m1_rid !== b.rid[3:0] || m1_rdata !== b.data
                      || m1_rresp !== b.resp || m1_rlast !== b.last || m0_rvalid !== 1'b0) begin
              bad++;
              $display("FAIL rand_m1_beat cyc=%0d: v=%b id=%h data=%h resp=%b last=%b m0v=%b want 1 %h %h %b %b 0",
                       cyc, m1_rvalid, m1_rid, m1_rdata, m1_rresp, m1_rlast, m0_rvalid,
                       b.rid[3:0], b.data, b.resp, b.last);
            end
            default: if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
              bad++;
              $display("FAIL rand_drop_beat cyc=%0d: m0v=%b m1v=%b want 0 0", cyc, m0_rvalid, m1_rvalid);
            end
          endcase
        end
      end
      total++;
      if ((m0_rvalid && m0_rready && hs_dest != 0) || (m1_rvalid && m1_rready && hs_dest != 1)) begin
        bad++;
        $display("FAIL rand_phantom_beat cyc=%0d: master accepted beat with slave dest %0d", cyc, hs_dest);
      end
      tick();
      cyc++;
    end
    total++;
    if (sq[0].size() + sq[1].size() + sq[2].size() != 0 || gi != exp_order.size()) begin
      bad++;
      $display("FAIL rand_drain: beats left %0d grants %0d want 0 and %0d",
               sq[0].size() + sq[1].size() + sq[2].size(), gi, exp_order.size());
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    test_reset();
    test_single_beat();
    test_stall_burst();
    test_round_robin();
    test_drop();
    test_reset_mid_burst();
    test_rid_change();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
